seg7_count_display: RTL and testbench
=====================================

Name: seg7_count_display

Overview:
- Consumer side of the 8-bit count bus driven by the button/counter test logic.
- Takes an 8-bit binary value on a load strobe and converts it to three BCD digits with a sequential double-dabble converter.
- Drives a time-multiplexed 3-digit common-anode 7-segment display with leading-zero blanking.
- Sits at board top level, between the counter output and the display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range ≥1.
- LZ_BLANK, 1, 1 = blank leading zeros; 0 = show all three digits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- value  input  8  binary value to display
- load  input  1  one-cycle strobe; samples value when ready=1
- ready  output  1  1 = converter idle, load accepted
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low, held off (1)
- digit_sel  output  3  digit enables, active-low; bit0 = ones, bit1 = tens, bit2 = hundreds

Behaviour:
- Reset (rst=0, async) values:
  - ready=1, seg=7'h7F, dp=1, digit_sel=3'b111.
  - Displayed BCD register = 0,0,0; scan counter = 0; digit index = 0; FSM = IDLE.
- FSM states: IDLE -> CONVERT -> COMMIT -> IDLE.
  - IDLE: load=1 at edge E0 latches value into the shift register and clears the BCD accumulator; ready=0 after E0.
  - CONVERT: edges E1..E8, one shift per edge. Before each shift, add 3 to any BCD nibble ≥5. The step counter is 3 bits and exits after the 8th shift.
  - COMMIT: edge E9 copies the 12-bit BCD result into the displayed register atomically; ready=1 after E9.
  - ready is therefore low for exactly 9 cycles. Back-to-back: load at E9+1 is accepted.
- load while ready=0 is ignored; it is neither queued nor able to corrupt the conversion.
- The displayed register changes only in COMMIT. The scan never shows a mix of old and new digits.
- Scan counter counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0->1->2->0.
  - With SCAN_DIV=1 the index advances every cycle.
- seg and digit_sel are registered and updated on the same edge as the index change, so there are no glitch cycles with mismatched digit/segments.
- Only one digit_sel bit is low at a time, or none when the current digit is blanked.
- Blanking (LZ_BLANK=1):
  - Hundreds is blanked if H=0.
  - Tens is blanked if H=0 and T=0.
  - Ones is never blanked.
  - A blanked slot drives digit_sel=3'b111 and seg=7'h7F for that slot's full duration.
- Segment codes (active-low, gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Any nibble >9 maps to 7'h7F; this is unreachable and is a checked assertion.
- Reset mid-conversion aborts it. The display returns to the reset state, and the first slot after reset release shows ones=0.
- Max value 255 -> BCD 2,5,5. The hundreds nibble never exceeds 2; the width is held at 4 bits for uniformity.

Decomposition:
- Package seg7_pkg holds:
  - FSM state enum (IDLE, CONVERT, COMMIT)
  - segment code constants SEG_0..SEG_9 and SEG_BLANK=7'h7F
  - a seg_encode(nibble) function
  - digit-index encoding constants
- Sub-module bin2bcd_seq: 8-bit sequential double dabble with start/done handshake and a 12-bit BCD output.
  - It owns the CONVERT step counter.
  - The top owns the FSM handshake, commit, scan and blanking.

Test Plan:
- Reset release, no load, SCAN_DIV=4 -> ready=1. Every 4 cycles digit_sel cycles 110, 111, 111 (blanked), repeating; seg=7'h40 in the ones slot, 7'h7F otherwise.
- load with value=8'd255, SCAN_DIV=4 -> ready low exactly 9 cycles. After COMMIT, slots show hundreds=7'h24, tens=7'h12, ones=7'h12, with digit_sel 011/101/110 respectively.
- value=8'd7, then value=8'd100 -> first case: hundreds and tens blanked, ones=7'h78. Second case: 7'h79, 7'h40, 7'h40, all three digits enabled since the tens zero is not leading. With LZ_BLANK=0, value=7 shows 7'h40, 7'h40, 7'h78.
- load value=8'd42, then load value=8'd99 three cycles later while ready=0 -> the second load is ignored and the display shows 4,2. A new load at the first ready=1 cycle is accepted and shows 9,9.
- load value=8'd200, assert rst=0 at cycle E4 -> outputs go to reset values immediately (async). After release, the display shows 0 with ready=1.
- Exhaustive sweep of value 0..255 with SCAN_DIV=1 -> decoded segments match the decimal value for every input; no cycle has more than one digit_sel bit low.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment display path.
// Segment codes are active-low in {g,f,e,d,c,b,a} order, for a common-anode display.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam int BIN_W = 8;
    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8 shift steps after start, 12-bit BCD result.
// done is high during the final shift cycle, so bcd is valid right after that edge.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0]       shift_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic [BCD_W-1:0]       adj;
    logic [2:0]             step_reg;
    logic                   busy_reg;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Add 3 to every nibble >= 5 before the shift so it carries correctly in decimal.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                             : bcd_reg[gi*4 +: 4];
    end

    assign shifted = {adj, shift_reg} << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            step_reg  <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            shift_reg <= bin;
            bcd_reg   <= '0;
            step_reg  <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            {bcd_reg, shift_reg} <= shifted;
            step_reg             <= step_reg + 3'd1;
            if (step_reg == 3'd7) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign done = busy_reg && (step_reg == 3'd7);
    assign bcd  = bcd_reg;

endmodule

// File: rtl/seg7_count_display.sv
// Latches an 8-bit count, converts it to BCD and scans it onto a 3-digit
// common-anode display with optional leading-zero blanking.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    output logic       ready,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit_sel
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    state_t           state_reg, state_next;
    logic             start;
    logic             commit;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_W-1:0] disp_reg;
    logic [CNT_W-1:0] scan_reg, scan_next;
    logic [1:0]       idx_reg, idx_next;
    logic [6:0]       seg_reg, seg_next;
    logic [2:0]       sel_reg, sel_next;
    logic [3:0]       nib;
    logic             blank;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Loads outside IDLE are dropped: start is only ever raised from IDLE.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    start      = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_reg <= '0;
        end else if (commit) begin
            disp_reg <= conv_bcd;
        end
    end

    always_comb begin
        scan_next = scan_reg + CNT_W'(1);
        idx_next  = idx_reg;
        if (scan_reg == SCAN_LAST) begin
            scan_next = '0;
            idx_next  = (idx_reg == DIG_HUNDREDS) ? DIG_ONES : idx_reg + 2'd1;
        end
    end

    // Outputs are decoded from the next index so digit enable and segments switch together.
    always_comb begin
        nib      = disp_reg[3:0];
        blank    = 1'b0;
        sel_next = 3'b110;
        case (idx_next)
            DIG_TENS: begin
                nib      = disp_reg[7:4];
                blank    = LZ_BLANK && (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0);
                sel_next = 3'b101;
            end
            DIG_HUNDREDS: begin
                nib      = disp_reg[11:8];
                blank    = LZ_BLANK && (disp_reg[11:8] == 4'd0);
                sel_next = 3'b011;
            end
            default: ;
        endcase
        seg_next = seg_encode(nib);
        if (blank) begin
            sel_next = 3'b111;
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_reg <= '0;
            idx_reg  <= DIG_ONES;
            seg_reg  <= SEG_BLANK;
            sel_reg  <= 3'b111;
        end else begin
            scan_reg <= scan_next;
            idx_reg  <= idx_next;
            seg_reg  <= seg_next;
            sel_reg  <= sel_next;
        end
    end

    assign seg       = seg_reg;
    assign digit_sel = sel_reg;
    assign dp        = 1'b1;

    a_bcd_range: assert property (@(posedge clk) disable iff (!rst)
        (disp_reg[3:0] <= 4'd9) && (disp_reg[7:4] <= 4'd9) && (disp_reg[11:8] <= 4'd9));

endmodule

// File: tb/tb_seg7_count_display.sv
// Bench for seg7_count_display: three instances (scan 4 blanking, scan 4 no blanking,
// scan 1 blanking) checked every cycle against a decimal-arithmetic display model.
module tb_seg7_count_display;

    localparam int DIV_A = 4;
    localparam int DIV_B = 4;
    localparam int DIV_C = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] value = 8'd0;
    logic       load = 1'b0;

    logic       ready_o [3];
    logic [6:0] seg_o   [3];
    logic       dp_o    [3];
    logic [2:0] sel_o   [3];

    int n_checks = 0;
    int n_errors = 0;
    int n_prints = 0;

    always #5 clk = ~clk;

    seg7_count_display #(.SCAN_DIV(DIV_A), .LZ_BLANK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .ready(ready_o[0]), .seg(seg_o[0]), .dp(dp_o[0]), .digit_sel(sel_o[0]));
    seg7_count_display #(.SCAN_DIV(DIV_B), .LZ_BLANK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .ready(ready_o[1]), .seg(seg_o[1]), .dp(dp_o[1]), .digit_sel(sel_o[1]));
    seg7_count_display #(.SCAN_DIV(DIV_C), .LZ_BLANK(1'b1)) dut_c (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .ready(ready_o[2]), .seg(seg_o[2]), .dp(dp_o[2]), .digit_sel(sel_o[2]));

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int  div_p [3] = '{DIV_A, DIV_B, DIV_C};
    int  lz_p  [3] = '{1, 0, 1};

    int         m_disp;
    int         m_pend;
    int         m_remaining;
    int         m_cnt [3];
    int         m_idx [3];
    logic [6:0] m_seg [3];
    logic [2:0] m_sel [3];

    // {digit_sel, seg} expected for a displayed decimal value in a given slot.
    function automatic logic [9:0] expect_slot(input int d, input int idx, input int lz);
        int h, t, o, dig;
        logic blank;
        logic [2:0] sel;
        h = d / 100;
        t = (d / 10) % 10;
        o = d % 10;
        dig = o;
        blank = 1'b0;
        if (idx == 1) begin
            dig = t;
            blank = (lz != 0) && (h == 0) && (t == 0);
        end else if (idx == 2) begin
            dig = h;
            blank = (lz != 0) && (h == 0);
        end
        sel = 3'b111;
        sel[idx] = 1'b0;
        if (blank) return {3'b111, 7'h7F};
        return {sel, seg_tab[dig]};
    endfunction

    task automatic model_reset();
        m_disp = 0;
        m_pend = 0;
        m_remaining = 0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_idx[i] = 0;
            m_seg[i] = 7'h7F;
            m_sel[i] = 3'b111;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (m_cnt[i] == div_p[i] - 1) begin
                        m_cnt[i] = 0;
                        m_idx[i] = (m_idx[i] + 1) % 3;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                    {m_sel[i], m_seg[i]} = expect_slot(m_disp, m_idx[i], lz_p[i]);
                end
                // A conversion occupies 9 edges after the accepting one; commit on the last.
                if (m_remaining == 0) begin
                    if (load) begin
                        m_pend = value;
                        m_remaining = 9;
                    end
                end else begin
                    m_remaining = m_remaining - 1;
                    if (m_remaining == 0) m_disp = m_pend;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            if (n_prints < 40) begin
                n_prints++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int zeros;
                zeros = 0;
                for (int b = 0; b < 3; b++) if (sel_o[i][b] == 1'b0) zeros++;
                chk($sformatf("ready[%0d]", i), int'(ready_o[i]), int'(m_remaining == 0));
                chk($sformatf("seg[%0d]", i), int'(seg_o[i]), int'(m_seg[i]));
                chk($sformatf("digit_sel[%0d]", i), int'(sel_o[i]), int'(m_sel[i]));
                chk($sformatf("dp[%0d]", i), int'(dp_o[i]), 1);
                chk($sformatf("onehot_sel[%0d]", i), int'(zeros <= 1), 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_o[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o[0]) chk("ready_timeout", 0, 1);
    endtask

    task automatic load_when_ready(input logic [7:0] v);
        wait_ready();
        value = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Record the segment pattern shown for each enabled digit over n cycles.
    task automatic capture(input int inst, input int n,
                           output logic [6:0] h, output logic [6:0] t, output logic [6:0] o);
        h = 7'h7F;
        t = 7'h7F;
        o = 7'h7F;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case (sel_o[inst])
                3'b011: h = seg_o[inst];
                3'b101: t = seg_o[inst];
                3'b110: o = seg_o[inst];
                default: ;
            endcase
        end
    endtask

    task automatic chk_digits(input string name, input int inst, input int n,
                              input logic [6:0] eh, input logic [6:0] et, input logic [6:0] eo);
        logic [6:0] h, t, o;
        capture(inst, n, h, t, o);
        chk({name, "_hundreds"}, int'(h), int'(eh));
        chk({name, "_tens"}, int'(t), int'(et));
        chk({name, "_ones"}, int'(o), int'(eo));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int low_cnt;
        repeat (3) @(posedge clk);
        chk("reset_ready", int'(ready_o[0]), 1);
        chk("reset_seg", int'(seg_o[0]), 7'h7F);
        chk("reset_sel", int'(sel_o[0]), 3'b111);
        @(negedge clk);
        rst = 1'b1;

        // Idle display: only the ones digit, showing 0.
        repeat (8) @(negedge clk);
        chk_digits("idle_zero", 0, 12, 7'h7F, 7'h7F, 7'h40);

        // 255: ready low for exactly 9 cycles, then 2,5,5.
        load_when_ready(8'd255);
        low_cnt = 0;
        while (!ready_o[0] && low_cnt < 20) begin
            low_cnt++;
            @(negedge clk);
        end
        chk("ready_low_cycles", low_cnt, 9);
        repeat (2) @(negedge clk);
        chk_digits("v255", 0, 12, 7'h24, 7'h12, 7'h12);

        // 7 with and without blanking, then 100 (inner zero not blanked).
        load_when_ready(8'd7);
        wait_ready();
        repeat (2) @(negedge clk);
        chk_digits("v7_lz", 0, 12, 7'h7F, 7'h7F, 7'h78);
        chk_digits("v7_nolz", 1, 12, 7'h40, 7'h40, 7'h78);
        load_when_ready(8'd100);
        wait_ready();
        repeat (2) @(negedge clk);
        chk_digits("v100", 0, 12, 7'h79, 7'h40, 7'h40);

        // 42, with a 99 load while busy that must be dropped.
        load_when_ready(8'd42);
        repeat (2) @(negedge clk);
        value = 8'd99;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        value = 8'd0;
        wait_ready();
        value = 8'd99;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load_at_first_ready", int'(ready_o[0]), 0);
        chk_digits("v42", 2, 3, 7'h7F, 7'h19, 7'h24);
        wait_ready();
        repeat (2) @(negedge clk);
        chk_digits("v99", 2, 3, 7'h7F, 7'h10, 7'h10);

        // Reset during a conversion of 200.
        load_when_ready(8'd200);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_ready[%0d]", i), int'(ready_o[i]), 1);
            chk($sformatf("abort_seg[%0d]", i), int'(seg_o[i]), 7'h7F);
            chk($sformatf("abort_sel[%0d]", i), int'(sel_o[i]), 3'b111);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk_digits("after_abort", 2, 3, 7'h7F, 7'h7F, 7'h40);
        chk("after_abort_ready", int'(ready_o[2]), 1);

        // Exhaustive sweep; the per-cycle model covers every committed value.
        for (int v = 0; v < 256; v++) begin
            load_when_ready(8'(v));
        end
        wait_ready();
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
